riscv_v_exe_seq: RTL

Sequencer in front of the vector execute ALU. It accepts one decoded vector instruction at a time from decode over a valid/ready handshake. It expands a register group (LMUL = 1, 2, 4 or 8) into one ALU pass per register, generating per-pass source and destination register addresses, first/last flags and writeback enables. It also handles single-pass v2i moves, multi-pass reductions with accumulator feedback, alignment checking and pipeline flush.

---
 rtl/riscv_v_exe_seq_if.sv | 51 +++++
 rtl/riscv_v_exe_seq.sv | 136 +++++++++++++
 2 files changed

// File: rtl/riscv_v_exe_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_v_exe_seq_if
// Purpose  : Issue and ALU-pass bundle between decode, sequencer and execute.
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_v_exe_seq_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  flush_i;
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [REG_ADDR_W-1:0] issue_vd_i;
    logic [REG_ADDR_W-1:0] issue_vs1_i;
    logic [REG_ADDR_W-1:0] issue_vs2_i;
    logic [1:0]            issue_lmul_log2_i;
    logic                  issue_vs1_scalar_i;
    logic                  issue_is_reduct_i;
    logic                  issue_is_v2i_i;
    logic                  alu_ready_i;
    logic                  alu_valid_o;
    logic [REG_ADDR_W-1:0] alu_vs1_o;
    logic [REG_ADDR_W-1:0] alu_vs2_o;
    logic [REG_ADDR_W-1:0] alu_vd_o;
    logic                  alu_first_o;
    logic                  alu_last_o;
    logic                  alu_accum_sel_o;
    logic                  alu_vec_wb_en_o;
    logic                  alu_int_wb_en_o;
    logic                  busy_o;
    logic                  illegal_o;

    modport slave (
        input  flush_i, issue_valid_i, issue_vd_i, issue_vs1_i, issue_vs2_i,
               issue_lmul_log2_i, issue_vs1_scalar_i, issue_is_reduct_i,
               issue_is_v2i_i, alu_ready_i,
        output issue_ready_o, alu_valid_o, alu_vs1_o, alu_vs2_o, alu_vd_o,
               alu_first_o, alu_last_o, alu_accum_sel_o, alu_vec_wb_en_o,
               alu_int_wb_en_o, busy_o, illegal_o
    );

    modport master (
        output flush_i, issue_valid_i, issue_vd_i, issue_vs1_i, issue_vs2_i,
               issue_lmul_log2_i, issue_vs1_scalar_i, issue_is_reduct_i,
               issue_is_v2i_i, alu_ready_i,
        input  issue_ready_o, alu_valid_o, alu_vs1_o, alu_vs2_o, alu_vd_o,
               alu_first_o, alu_last_o, alu_accum_sel_o, alu_vec_wb_en_o,
               alu_int_wb_en_o, busy_o, illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/riscv_v_exe_seq.sv
`default_nettype none
// ============================================================================
// Module   : riscv_v_exe_seq
// Purpose  : Expands a vector register group into per-register ALU passes.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_v_exe_seq #(
    parameter int REG_ADDR_W    = 5,
    parameter int MAX_LMUL_LOG2 = 3
) (
    input logic              clk,
    input logic              rst_n,
    riscv_v_exe_seq_if.slave bus
);
    localparam int CNT_W = MAX_LMUL_LOG2;
    localparam logic [REG_ADDR_W-1:0] c_addr_one = 1;
    localparam logic [CNT_W-1:0]      c_cnt_one  = 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]      r_last_idx, w_issue_last_idx;
    logic [REG_ADDR_W-1:0] r_vd, r_vs1, r_vs2;
    logic [REG_ADDR_W-1:0] w_mask, w_k;
    logic                  r_vs1_hold, r_reduct, r_v2i, r_illegal;
    logic                  w_illegal_nxt, w_load, w_misaligned;
    logic                  w_valid, w_fire, w_last;

    // Only registers that get stepped through the group must be group-aligned;
    // a reduction's vd and vs1 are single registers.
    always_comb begin
        w_mask       = (c_addr_one << bus.issue_lmul_log2_i) - c_addr_one;
        w_misaligned = !bus.issue_is_v2i_i &&
                       (((bus.issue_vs2_i & w_mask) != '0) ||
                        (!bus.issue_is_reduct_i && ((bus.issue_vd_i & w_mask) != '0)) ||
                        (!(bus.issue_vs1_scalar_i || bus.issue_is_reduct_i) &&
                         ((bus.issue_vs1_i & w_mask) != '0)));
        w_issue_last_idx = bus.issue_is_v2i_i ? '0
                         : (c_cnt_one << bus.issue_lmul_log2_i) - c_cnt_one;
    end

    assign w_valid = (r_state == RUN);
    assign w_fire  = w_valid & bus.alu_ready_i;
    assign w_last  = (r_cnt == r_last_idx);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_load        = 1'b0;
        w_illegal_nxt = 1'b0;
        if (bus.flush_i) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.issue_valid_i) begin
                        if (w_misaligned) begin
                            w_illegal_nxt = 1'b1;
                        end else begin
                            w_load      = 1'b1;
                            w_state_nxt = RUN;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        if (w_last) begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vd       <= '0;
            r_vs1      <= '0;
            r_vs2      <= '0;
            r_last_idx <= '0;
            r_vs1_hold <= 1'b0;
            r_reduct   <= 1'b0;
            r_v2i      <= 1'b0;
        end else if (w_load) begin
            r_vd       <= bus.issue_vd_i;
            r_vs1      <= bus.issue_vs1_i;
            r_vs2      <= bus.issue_vs2_i;
            r_last_idx <= w_issue_last_idx;
            r_vs1_hold <= bus.issue_vs1_scalar_i | bus.issue_is_reduct_i;
            r_reduct   <= bus.issue_is_reduct_i;
            r_v2i      <= bus.issue_is_v2i_i;
        end
    end

    assign w_k = REG_ADDR_W'(r_cnt);

    assign bus.issue_ready_o   = (r_state == IDLE);
    assign bus.busy_o          = w_valid;
    assign bus.illegal_o       = r_illegal;
    assign bus.alu_valid_o     = w_valid;
    assign bus.alu_vs2_o       = r_vs2 + w_k;
    assign bus.alu_vs1_o       = r_vs1_hold ? r_vs1 : (r_vs1 + w_k);
    assign bus.alu_vd_o        = r_reduct ? r_vd : (r_vd + w_k);
    assign bus.alu_first_o     = w_valid & (r_cnt == '0);
    assign bus.alu_last_o      = w_valid & w_last;
    assign bus.alu_accum_sel_o = w_valid & r_reduct & (r_cnt != '0);
    assign bus.alu_vec_wb_en_o = w_valid & ~r_v2i & (~r_reduct | w_last);
    assign bus.alu_int_wb_en_o = w_valid & r_v2i;
endmodule
`default_nettype wire
